// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with a write-only MMIO (VGA character buffer) window.
// One transaction in flight; grant is issued combinationally from IDLE, completion via ack/err pulses.
module mem_arbiter #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] MMIO_BASE    = 32'h0007_0000,
  parameter int unsigned WR_TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [1:0]           size0,
  input  logic [1:0]           size1,
  input  logic [31:0]          addr0,
  input  logic [31:0]          addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 err0,
  output logic                 err1,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [31:0]          mem_addr,
  output logic [1:0]           mem_write,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_done,
  input  logic                 mem_error,
  output logic                 vga_we,
  output logic [12:0]          vga_addr,
  output logic [WORD_SIZE-1:0] vga_data,
  output logic                 busy
);

  localparam int unsigned MAXC = (WR_TIMEOUT > READ_LATENCY) ? WR_TIMEOUT : READ_LATENCY;
  localparam int unsigned CW   = ($clog2(MAXC + 1) > 1) ? $clog2(MAXC + 1) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(WR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    VGA_WRITE,
    RESP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_port;
  logic                 r_prio1;
  logic                 r_err;
  logic [CW-1:0]        r_cnt;
  logic [1:0]           r_size;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [31:0]          r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;
  logic [12:0]          r_vga_addr;
  logic [WORD_SIZE-1:0] r_vga_data;

  logic                 w_sel;
  logic                 w_grant;
  logic [1:0]           w_size;
  logic [31:0]          w_addr;
  logic [WORD_SIZE-1:0] w_wdata;
  logic [WORD_SIZE-1:0] w_wshift;
  logic                 w_misal;
  logic                 w_mmio;
  logic                 w_rd_fail;
  logic                 w_wr_fail;

  always_comb begin
    // Port 1 wins only when alone or when the pointer favours it.
    w_sel    = req1 & (~req0 | r_prio1);
    w_grant  = rst & (req0 | req1) & (r_state == IDLE);
    w_size   = w_sel ? size1  : size0;
    w_addr   = w_sel ? addr1  : addr0;
    w_wdata  = w_sel ? wdata1 : wdata0;
    w_misal  = ((w_size == 2'd2) & w_addr[0]) | ((w_size == 2'd3) & (w_addr[1:0] != 2'b00));
    w_mmio   = (w_addr >= MMIO_BASE);
    w_wshift = w_wdata;
    case (w_size)
      2'd1:    w_wshift = w_wdata << 24;
      2'd2:    w_wshift = w_wdata << 16;
      default: w_wshift = w_wdata;
    endcase
    w_rd_fail = mem_error;
    w_wr_fail = mem_error | (~mem_done & (r_cnt == TO_LAST));

    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          if (w_misal)             w_next = RESP;
          else if (w_size == 2'd0) w_next = w_mmio ? RESP : READ_WAIT;
          else                     w_next = w_mmio ? VGA_WRITE : WRITE_WAIT;
        end
      end
      READ_WAIT:  if (mem_error || r_cnt == RD_LAST) w_next = RESP;
      WRITE_WAIT: if (mem_error || mem_done || r_cnt == TO_LAST) w_next = RESP;
      VGA_WRITE:  w_next = RESP;
      RESP:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase

    gnt0      = w_grant & ~w_sel;
    gnt1      = w_grant & w_sel;
    ack0      = (r_state == RESP) & ~r_err & ~r_port;
    ack1      = (r_state == RESP) & ~r_err & r_port;
    err0      = (r_state == RESP) & r_err & ~r_port;
    err1      = (r_state == RESP) & r_err & r_port;
    mem_write = (r_state == WRITE_WAIT) ? r_size : 2'd0;
    vga_we    = (r_state == VGA_WRITE);
    busy      = (r_state != IDLE);
    rdata     = r_rdata;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    vga_addr  = r_vga_addr;
    vga_data  = r_vga_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_port      <= 1'b0;
      r_prio1     <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_vga_addr  <= '0;
      r_vga_data  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_port  <= w_sel;
            r_prio1 <= ~w_sel;
            r_err   <= w_misal;
            r_cnt   <= '0;
            r_size  <= w_size;
            if (!w_misal) begin
              if (w_size == 2'd0) begin
                if (w_mmio) r_rdata    <= '0;
                else        r_mem_addr <= w_addr;
              end else if (w_mmio) begin
                r_vga_addr <= w_addr[12:0];
                r_vga_data <= w_wdata;
              end else begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wshift;
              end
            end
          end
        end
        READ_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_rd_fail)             r_err   <= 1'b1;
          else if (r_cnt == RD_LAST) r_rdata <= mem_rdata;
        end
        WRITE_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_wr_fail) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: arbitration, reads, memory/VGA writes,
// misalignment, timeout, memory error and asynchronous reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [1:0]  size0, size1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, ack0, ack1, err0, err1;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [1:0]  mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_error;
  logic        vga_we;
  logic [12:0] vga_addr;
  logic [31:0] vga_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .WORD_SIZE   (32),
    .READ_LATENCY(2),
    .MMIO_BASE   (32'h0007_0000),
    .WR_TIMEOUT  (255)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .size0    (size0),
    .size1    (size1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .ack0     (ack0),
    .ack1     (ack1),
    .err0     (err0),
    .err1     (err1),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_done (mem_done),
    .mem_error(mem_error),
    .vga_we   (vga_we),
    .vga_addr (vga_addr),
    .vga_data (vga_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0; req0 = 1'b1; req1 = 1'b0; size0 = 2'd0; size1 = 2'd0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_rdata = '0; mem_done = 1'b0; mem_error = 1'b0;

    // Reset state, with a request pending that must not be granted
    #12;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_vga_we", 32'(vga_we), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ack0", 32'(ack0), 0);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nxt;

    // Round-robin: both held, four reads, grants 0,1,0,1
    req0 = 1'b1; size0 = 2'd0; addr0 = 32'h10;
    req1 = 1'b1; size1 = 2'd0; addr1 = 32'h20;
    #1;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (!(gnt0 | gnt1) && n < 20) begin nxt; n++; end
      chk("rr_gnt_seen", 32'(gnt0 | gnt1), 1);
      chk("rr_gnt_port", 32'(gnt1), t % 2);
      mem_rdata = 32'hC0DE_0000 + 32'(t);
      nxt;
      chk("rr_no_gnt_busy", 32'(gnt0 | gnt1), 0);
      n = 0;
      while (!(ack0 | ack1) && n < 20) begin nxt; n++; end
      chk("rr_ack_seen", 32'(ack0 | ack1), 1);
      chk("rr_ack_port", 32'(ack1), t % 2);
      chk("rr_rdata", rdata, 32'hC0DE_0000 + 32'(t));
      if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
      nxt;
    end
    chk("rr_idle_after", 32'(busy), 0);

    // Read 0x100, latency 2: gnt cycle 0, ack with data cycle 3
    req0 = 1'b1; size0 = 2'd0; addr0 = 32'h100; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_gnt0", 32'(gnt0), 1);
    chk("rd_gnt1", 32'(gnt1), 0);
    nxt; req0 = 1'b0;
    chk("rd_busy", 32'(busy), 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_write", 32'(mem_write), 0);
    chk("rd_ack_c1", 32'(ack0), 0);
    nxt;
    chk("rd_ack_c2", 32'(ack0), 0);
    nxt;
    chk("rd_ack_c3", 32'(ack0), 1);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd_err_c3", 32'(err0), 0);
    nxt;
    chk("rd_ack_c4", 32'(ack0), 0);
    chk("rd_busy_c4", 32'(busy), 0);

    // Byte write 0xAB to 0x204 from port 1, mem_done in the fifth wait cycle
    req1 = 1'b1; size1 = 2'd1; addr1 = 32'h204; wdata1 = 32'hAB;
    #1;
    chk("bw_gnt1", 32'(gnt1), 1);
    nxt; req1 = 1'b0;
    chk("bw_mem_addr", mem_addr, 32'h204);
    for (int k = 1; k <= 5; k++) begin
      chk("bw_mem_write", 32'(mem_write), 1);
      chk("bw_mem_wdata", mem_wdata, 32'hAB00_0000);
      chk("bw_no_ack", 32'(ack1), 0);
      if (k == 5) mem_done = 1'b1;
      nxt;
    end
    mem_done = 1'b0;
    chk("bw_mem_write_off", 32'(mem_write), 0);
    chk("bw_ack1", 32'(ack1), 1);
    chk("bw_err1", 32'(err1), 0);
    nxt;
    chk("bw_idle", 32'(busy), 0);

    // VGA word write
    req0 = 1'b1; size0 = 2'd3; addr0 = 32'h0007_0010; wdata0 = 32'h41;
    #1;
    chk("vga_gnt0", 32'(gnt0), 1);
    nxt; req0 = 1'b0;
    chk("vga_we", 32'(vga_we), 1);
    chk("vga_addr", 32'(vga_addr), 32'h10);
    chk("vga_data", vga_data, 32'h41);
    chk("vga_mem_write", 32'(mem_write), 0);
    chk("vga_no_ack", 32'(ack0), 0);
    nxt;
    chk("vga_we_off", 32'(vga_we), 0);
    chk("vga_ack0", 32'(ack0), 1);
    nxt;

    // Misaligned half and word writes
    req0 = 1'b1; size0 = 2'd2; addr0 = 32'h103; wdata0 = 32'h1234;
    #1;
    chk("mis_h_gnt0", 32'(gnt0), 1);
    nxt; req0 = 1'b0;
    chk("mis_h_err0", 32'(err0), 1);
    chk("mis_h_ack0", 32'(ack0), 0);
    chk("mis_h_mem_write", 32'(mem_write), 0);
    chk("mis_h_vga_we", 32'(vga_we), 0);
    nxt;
    chk("mis_h_err_off", 32'(err0), 0);
    chk("mis_h_idle", 32'(busy), 0);
    req0 = 1'b1; size0 = 2'd3; addr0 = 32'h102;
    #1;
    chk("mis_w_gnt0", 32'(gnt0), 1);
    nxt; req0 = 1'b0;
    chk("mis_w_err0", 32'(err0), 1);
    nxt;

    // Aligned half write at 0x102 is legal
    req0 = 1'b1; size0 = 2'd2; addr0 = 32'h102; wdata0 = 32'h1234;
    #1;
    nxt; req0 = 1'b0;
    chk("hw_mem_write", 32'(mem_write), 2);
    chk("hw_mem_wdata", mem_wdata, 32'h1234_0000);
    mem_done = 1'b1;
    nxt; mem_done = 1'b0;
    chk("hw_ack0", 32'(ack0), 1);
    chk("hw_err0", 32'(err0), 0);
    nxt;

    // Word just below the MMIO window goes to memory
    req0 = 1'b1; size0 = 2'd3; addr0 = 32'h0006_FFFC; wdata0 = 32'h77;
    #1;
    nxt; req0 = 1'b0;
    chk("blw_mem_write", 32'(mem_write), 3);
    chk("blw_vga_we", 32'(vga_we), 0);
    chk("blw_mem_wdata", mem_wdata, 32'h77);
    mem_done = 1'b1;
    nxt; mem_done = 1'b0;
    chk("blw_ack0", 32'(ack0), 1);
    nxt;

    // Read exactly at MMIO_BASE returns zero
    req1 = 1'b1; size1 = 2'd0; addr1 = 32'h0007_0000; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("mmrd_gnt1", 32'(gnt1), 1);
    nxt; req1 = 1'b0;
    chk("mmrd_ack1", 32'(ack1), 1);
    chk("mmrd_rdata", rdata, 32'h0);
    nxt;

    // Write timeout: mem_done never arrives
    req0 = 1'b1; size0 = 2'd3; addr0 = 32'h300; wdata0 = 32'h55;
    #1;
    nxt; req0 = 1'b0;
    n = 0;
    while (mem_write == 2'd3 && n < 300) begin n++; nxt; end
    chk("to_wait_cycles", 32'(n), 255);
    chk("to_err0", 32'(err0), 1);
    chk("to_ack0", 32'(ack0), 0);
    chk("to_mem_write", 32'(mem_write), 0);
    nxt;

    // Memory error during a read
    req0 = 1'b1; size0 = 2'd0; addr0 = 32'h400;
    #1;
    nxt; req0 = 1'b0; mem_error = 1'b1;
    nxt; mem_error = 1'b0;
    chk("merr_err0", 32'(err0), 1);
    chk("merr_ack0", 32'(ack0), 0);
    nxt;
    chk("merr_idle", 32'(busy), 0);

    // Asynchronous reset in WRITE_WAIT drops the transaction
    req0 = 1'b1; size0 = 2'd3; addr0 = 32'h500; wdata0 = 32'h99;
    #1;
    nxt; req0 = 1'b0;
    chk("arst_pre_mem_write", 32'(mem_write), 3);
    chk("arst_pre_busy", 32'(busy), 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_mem_write", 32'(mem_write), 0);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      nxt;
      if (ack0 | err0) n++;
    end
    chk("arst_no_resp", 32'(n), 0);

    // Pointer favours port 0 again after reset
    req0 = 1'b1; size0 = 2'd0; addr0 = 32'h600;
    req1 = 1'b1; size1 = 2'd0; addr1 = 32'h700;
    #1;
    chk("arst_rr_gnt0", 32'(gnt0), 1);
    chk("arst_rr_gnt1", 32'(gnt1), 0);
    nxt; req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) nxt;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
